// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory loader and its program store.
// Address and instruction widths are chosen to match the core's PC and INSTR ports.
package imem_pkg;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 128;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN
    } ld_state_e;

endpackage

// File: rtl/imem_ram.sv
// Program store: one synchronous write port and one asynchronous read port.
// The array has no reset, so its contents survive a system reset.
module imem_ram
    import imem_pkg::*;
(
    input  logic   CLK,
    input  logic   we,
    input  addr_t  waddr,
    input  instr_t wdata,
    input  addr_t  raddr,
    output instr_t rdata
);

    instr_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a 128-byte program plus checksum over a valid/ready stream and holds the
// core in reset until the image checks out; then serves INSTR from the core's PC.
module imem_loader
    import imem_pkg::*;
(
    input  logic   CLK,
    input  logic   RSTN,
    input  logic   LD_START,
    input  logic   LD_VALID,
    input  instr_t LD_DATA,
    output logic   LD_READY,
    output logic   LD_DONE,
    output logic   LD_ERR,
    input  addr_t  PC,
    output instr_t INSTR,
    output logic   CORE_RSTN
);

    ld_state_e state, state_nxt;
    addr_t     addr, addr_nxt;
    instr_t    sum, sum_nxt;
    instr_t    sum_plus;
    instr_t    rdata;
    logic      done_nxt, err_nxt;
    logic      mem_we;
    logic      beat;
    logic      core_rstn_q;

    assign LD_READY = (state == LOAD) || (state == CHECK);
    assign beat     = LD_VALID && LD_READY;
    assign sum_plus = sum + LD_DATA;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            addr        <= '0;
            sum         <= '0;
            LD_DONE     <= 1'b0;
            LD_ERR      <= 1'b0;
            core_rstn_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            sum         <= sum_nxt;
            LD_DONE     <= done_nxt;
            LD_ERR      <= err_nxt;
            // Release only once RUN has lasted a full cycle
            core_rstn_q <= (state == RUN) && (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        sum_nxt   = sum;
        done_nxt  = LD_DONE;
        err_nxt   = LD_ERR;
        mem_we    = 1'b0;

        // LD_START wins over any beat in the same cycle, so that byte is dropped
        if (LD_START) begin
            state_nxt = LOAD;
            addr_nxt  = '0;
            sum_nxt   = '0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (beat) begin
                        mem_we   = 1'b1;
                        addr_nxt = addr + addr_t'(1);
                        sum_nxt  = sum_plus;
                        if (addr == addr_t'(DEPTH - 1)) begin
                            state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (beat) begin
                        if (sum_plus == '0) begin
                            state_nxt = RUN;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    imem_ram u_ram (
        .CLK   (CLK),
        .we    (mem_we),
        .waddr (addr),
        .wdata (LD_DATA),
        .raddr (PC),
        .rdata (rdata)
    );

    // The core is held in reset outside RUN, so it only ever sees NOPs there
    assign INSTR     = (state == RUN) ? rdata : '0;
    assign CORE_RSTN = core_rstn_q && !((state == RUN) && LD_START);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader with a byte-array reference of the loaded image.
// Pass/fail of each load is predicted from the arithmetic sum of the streamed bytes.
module tb_imem_loader;

    logic       CLK      = 1'b0;
    logic       RSTN     = 1'b0;
    logic       LD_START = 1'b0;
    logic       LD_VALID = 1'b0;
    logic [7:0] LD_DATA  = 8'h00;
    logic       LD_READY;
    logic       LD_DONE;
    logic       LD_ERR;
    logic [6:0] PC       = 7'd0;
    logic [7:0] INSTR;
    logic       CORE_RSTN;

    int checks = 0;
    int errors = 0;

    logic [7:0] img    [129];
    logic [7:0] refMem [128];
    bit         expRun = 1'b0;

    imem_loader dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .LD_START  (LD_START),
        .LD_VALID  (LD_VALID),
        .LD_DATA   (LD_DATA),
        .LD_READY  (LD_READY),
        .LD_DONE   (LD_DONE),
        .LD_ERR    (LD_ERR),
        .PC        (PC),
        .INSTR     (INSTR),
        .CORE_RSTN (CORE_RSTN)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps);
        int waitCnt;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        @(negedge CLK);
        LD_VALID = 1'b1;
        LD_DATA  = b;
        waitCnt  = 0;
        while (!LD_READY && waitCnt < 20) begin
            @(negedge CLK);
            waitCnt++;
        end
        if (!LD_READY) begin
            checkOutput("readyTimeout", 32'd0, 32'd1);
        end else begin
            @(posedge CLK);
        end
        #1 LD_VALID = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge CLK);
        LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
    endtask

    // Stream img[0..128]; the model decides pass/fail from the plain byte sum
    task automatic applyStimulus(input bit gaps, input bit doStart);
        int  total;
        bit  pass;
        if (doStart) pulseStart();
        for (int i = 0; i < 129; i++) begin
            sendByte(img[i], gaps);
            if (i == 64) begin
                checkOutput("midLoadInstr", {24'd0, INSTR}, 32'd0);
                checkOutput("midLoadCoreRstn", {31'd0, CORE_RSTN}, 32'd0);
            end
        end
        total = 0;
        for (int i = 0; i < 129; i++) total += int'(img[i]);
        pass = (total % 256) == 0;
        if (pass) begin
            for (int i = 0; i < 128; i++) refMem[i] = img[i];
        end
        expRun = pass;
        @(negedge CLK);
        checkOutput("ldDone", {31'd0, LD_DONE}, {31'd0, pass});
        checkOutput("ldErr", {31'd0, LD_ERR}, {31'd0, !pass});
        checkOutput("coreRstnFirst", {31'd0, CORE_RSTN}, 32'd0);
        checkOutput("readyAfter", {31'd0, LD_READY}, 32'd0);
        @(negedge CLK);
        checkOutput("coreRstnSecond", {31'd0, CORE_RSTN}, {31'd0, pass});
    endtask

    task automatic checkFetch(input logic [6:0] pc);
        @(negedge CLK);
        PC = pc;
        #1;
        checkOutput($sformatf("instr@%0h", pc), {24'd0, INSTR}, expRun ? {24'd0, refMem[pc]} : 32'd0);
    endtask

    task automatic randomGoodImage();
        int total;
        total = 0;
        for (int i = 0; i < 128; i++) begin
            img[i] = 8'($urandom);
            total += int'(img[i]);
        end
        img[128] = 8'((256 - (total % 256)) % 256);
    endtask

    initial begin
        repeat (10) begin
            @(negedge CLK);
            checkOutput("resetOutputs", {20'd0, CORE_RSTN, LD_READY, LD_DONE, LD_ERR, INSTR}, 32'd0);
        end
        RSTN = 1'b1;
        @(negedge CLK);

        // Counting pattern, correct checksum
        for (int i = 0; i < 128; i++) img[i] = 8'(i);
        img[128] = 8'h40;
        applyStimulus(1'b0, 1'b1);
        checkFetch(7'h05);
        checkFetch(7'h7F);

        // Same pattern, wrong checksum
        img[128] = 8'h41;
        applyStimulus(1'b0, 1'b1);
        checkOutput("badStateReady", {31'd0, LD_READY}, 32'd0);
        checkFetch(7'h05);
        checkFetch(7'(($urandom)));

        // Constant bytes with random valid gaps: fail then pass
        for (int i = 0; i < 128; i++) img[i] = 8'hA5;
        img[128] = 8'hB0;
        applyStimulus(1'b1, 1'b1);
        img[128] = 8'h80;
        applyStimulus(1'b1, 1'b1);
        checkFetch(7'd0);
        checkFetch(7'd63);
        checkFetch(7'd127);

        // Restart after 50 bytes with a colliding beat that must be dropped
        pulseStart();
        for (int i = 0; i < 50; i++) sendByte(8'($urandom), 1'b0);
        @(negedge CLK);
        LD_START = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA  = 8'hEE;
        @(negedge CLK);
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        checkOutput("restartReady", {31'd0, LD_READY}, 32'd1);
        randomGoodImage();
        img[128] = 8'(img[128] + img[0] - 8'h3C);
        img[0]   = 8'h3C;
        applyStimulus(1'b1, 1'b0);
        checkFetch(7'd0);
        for (int i = 0; i < 4; i++) checkFetch(7'($urandom));

        // Reload while running
        @(negedge CLK);
        LD_START = 1'b1;
        #1;
        checkOutput("coreRstnDrop", {31'd0, CORE_RSTN}, 32'd0);
        @(negedge CLK);
        LD_START = 1'b0;
        checkOutput("reloadDoneClr", {31'd0, LD_DONE}, 32'd0);
        checkOutput("reloadReady", {31'd0, LD_READY}, 32'd1);
        expRun = 1'b0;
        randomGoodImage();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) checkFetch(7'($urandom));

        // Asynchronous reset while running, between clock edges
        @(negedge CLK);
        #2 RSTN = 1'b0;
        #1;
        checkOutput("asyncCoreRstn", {31'd0, CORE_RSTN}, 32'd0);
        checkOutput("asyncInstr", {24'd0, INSTR}, 32'd0);
        checkOutput("asyncDone", {31'd0, LD_DONE}, 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        expRun = 1'b0;
        @(negedge CLK);
        checkOutput("postResetReady", {31'd0, LD_READY}, 32'd0);
        checkFetch(7'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
